dircc_node_msg_rx_writer: RTL and testbench

- Receive-side stage that feeds the 16-bit second port (s2) of a node's dual-port processing memory.
- Accepts Avalon-ST 16-bit flits from the on-chip network and writes each packet into a slot of a ring buffer inside that memory.
- Writes a length/status word per slot, tracks occupancy, and raises an interrupt level for the node's Nios, which frees slots through a release pulse.

---
 rtl/dircc_msg_pkg.sv | 26 ++
 rtl/dircc_slot_ring_ctrl.sv | 64 ++++++
 rtl/dircc_node_msg_rx_writer.sv | 131 +++++++++++++
 tb/tb_dircc_node_msg_rx_writer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dircc_msg_pkg.sv
// Shared definitions for the node message receive writer.
// The length-word layout here must match the Nios driver header.
package dircc_msg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    COMMIT = 2'd2
  } rx_state_e;

  // Length word: [15] truncated, [14] reserved (0), [13:0] flit count
  localparam int LEN_TRUNC_BIT = 15;
  localparam int LEN_CNT_W     = 14;

  localparam logic [LEN_CNT_W-1:0] LEN_CNT_MAX = '1;

  function automatic logic [15:0] len_word(input logic trunc,
                                           input logic [LEN_CNT_W-1:0] cnt);
    logic [15:0] w;
    w                = '0;
    w[LEN_CNT_W-1:0] = cnt;
    w[LEN_TRUNC_BIT] = trunc;
    return w;
  endfunction

endpackage

// File: rtl/dircc_slot_ring_ctrl.sv
// Slot ring bookkeeping: write/read pointers, filled count, releases.
// A commit advances wr_slot one cycle after the length write is registered
// (the cycle it is on the bus), and bumps used one cycle after that, so the
// CPU never sees a slot counted before its length word has landed.
module dircc_slot_ring_ctrl #(
  parameter  int NUM_SLOTS = 8,
  localparam int SLOT_W    = $clog2(NUM_SLOTS),
  localparam int USED_W    = SLOT_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              commit_i,
  input  logic              release_i,
  output logic [SLOT_W-1:0] wr_slot_o,
  output logic [SLOT_W-1:0] fill_slot_o,
  output logic [SLOT_W-1:0] rd_slot_o,
  output logic [USED_W-1:0] used_o,
  output logic              full_o,
  output logic              rel_err_o
);

  logic              adv_q, inc_q;
  logic [SLOT_W-1:0] wr_q, rd_q;
  logic [USED_W-1:0] used_q;
  logic [USED_W-1:0] reserved;
  logic              rel_ok;

  assign rel_ok    = release_i && (used_q != '0);
  assign rel_err_o = release_i && (used_q == '0);

  // Slot for the next/current packet must already account for a commit
  // whose wr_slot advance is still in flight.
  assign fill_slot_o = wr_q + SLOT_W'(adv_q);

  // Committed-but-not-yet-counted slots still occupy the ring.
  assign reserved = used_q + USED_W'(adv_q) + USED_W'(inc_q);
  assign full_o   = (reserved >= USED_W'(NUM_SLOTS));

  assign wr_slot_o = wr_q;
  assign rd_slot_o = rd_q;
  assign used_o    = used_q;

  // Pointer and occupancy update; concurrent commit and release cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      adv_q  <= 1'b0;
      inc_q  <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
      used_q <= '0;
    end else begin
      adv_q <= commit_i;
      inc_q <= adv_q;
      if (adv_q)  wr_q <= wr_q + 1'b1;
      if (rel_ok) rd_q <= rd_q + 1'b1;
      case ({inc_q, rel_ok})
        2'b10:   used_q <= used_q + 1'b1;
        2'b01:   used_q <= used_q - 1'b1;
        default: used_q <= used_q;
      endcase
    end
  end

endmodule

// File: rtl/dircc_node_msg_rx_writer.sv
// Receive-side writer: takes Avalon-ST flits from the network and writes
// each packet into a ring slot of the node's s2 memory port, followed by a
// length/status word in word 0 of the slot.
module dircc_node_msg_rx_writer
  import dircc_msg_pkg::*;
#(
  parameter  int BASE_ADDR  = 16384,
  parameter  int NUM_SLOTS  = 8,
  parameter  int SLOT_WORDS = 256,
  parameter  int ADDR_W     = 15,
  localparam int SLOT_W     = $clog2(NUM_SLOTS),
  localparam int USED_W     = SLOT_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [15:0]       mem_writedata,
  output logic [1:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic              cpu_release,
  input  logic              irq_enable,
  output logic [SLOT_W-1:0] rd_slot,
  output logic [SLOT_W-1:0] wr_slot,
  output logic [USED_W-1:0] used,
  output logic              irq,
  output logic [7:0]        err_count
);

  rx_state_e            state_q;
  logic [LEN_CNT_W-1:0] cnt_q, cnt_inc;
  logic                 trunc_q;
  logic [7:0]           err_q;
  logic                 mem_wr_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [15:0]          mem_data_q;

  logic [SLOT_W-1:0] fill_slot;
  logic [ADDR_W-1:0] slot_base;
  logic              full, rel_err, fsm_err, acc;
  logic [8:0]        err_sum;

  dircc_slot_ring_ctrl #(.NUM_SLOTS(NUM_SLOTS)) u_ring (
    .clk        (clk),
    .reset      (reset),
    .commit_i   (state_q == COMMIT),
    .release_i  (cpu_release),
    .wr_slot_o  (wr_slot),
    .fill_slot_o(fill_slot),
    .rd_slot_o  (rd_slot),
    .used_o     (used),
    .full_o     (full),
    .rel_err_o  (rel_err)
  );

  // Ready comes only from registered state (and reset), never from in_valid.
  assign in_ready = ~reset & (((state_q == IDLE) & ~full) | (state_q == DATA));
  assign acc      = in_valid & in_ready;

  assign slot_base = ADDR_W'(BASE_ADDR) + (ADDR_W'(fill_slot) << $clog2(SLOT_WORDS));
  assign cnt_inc   = (cnt_q == LEN_CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Stray non-sop in IDLE, or sop in the middle of a packet.
  assign fsm_err = acc & (((state_q == IDLE) & ~in_sop) | ((state_q == DATA) & in_sop));
  assign err_sum = {1'b0, err_q} + 9'(fsm_err) + 9'(rel_err);

  assign mem_address    = mem_addr_q;
  assign mem_write      = mem_wr_q;
  assign mem_chipselect = mem_wr_q;
  assign mem_writedata  = mem_data_q;
  assign mem_byteenable = {2{mem_wr_q}};
  assign mem_clken      = 1'b1;
  assign irq            = irq_enable & (used != '0);
  assign err_count      = err_q;

  // Packet FSM with registered memory-write outputs and error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      trunc_q    <= 1'b0;
      err_q      <= '0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      mem_wr_q <= 1'b0;
      err_q    <= err_sum[8] ? 8'hFF : err_sum[7:0];
      case (state_q)
        IDLE: begin
          if (acc && in_sop) begin
            mem_wr_q   <= 1'b1;
            mem_addr_q <= slot_base + ADDR_W'(1);
            mem_data_q <= in_data;
            cnt_q      <= LEN_CNT_W'(1);
            trunc_q    <= 1'b0;
            state_q    <= in_eop ? COMMIT : DATA;
          end
        end
        DATA: begin
          if (acc) begin
            cnt_q <= cnt_inc;
            // Payload beyond the slot is counted but dropped.
            if (int'(cnt_inc) < SLOT_WORDS) begin
              mem_wr_q   <= 1'b1;
              mem_addr_q <= slot_base + ADDR_W'(cnt_inc);
              mem_data_q <= in_data;
            end else begin
              trunc_q <= 1'b1;
            end
            if (in_eop) state_q <= COMMIT;
          end
        end
        COMMIT: begin
          mem_wr_q   <= 1'b1;
          mem_addr_q <= slot_base;
          mem_data_q <= len_word(trunc_q, cnt_q);
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dircc_node_msg_rx_writer.sv
// Self-checking bench: expected memory writes go into a scoreboard as
// flits are driven and are compared as the DUT performs them.
module tb_dircc_node_msg_rx_writer;

  localparam int BASE  = 16384;
  localparam int NSLOT = 8;
  localparam int SW    = 256;

  logic        clk, reset;
  logic        in_valid, in_ready, in_sop, in_eop;
  logic [15:0] in_data;
  logic [14:0] mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [15:0] mem_writedata;
  logic [1:0]  mem_byteenable;
  logic        cpu_release, irq_enable, irq;
  logic [2:0]  rd_slot, wr_slot;
  logic [3:0]  used;
  logic [7:0]  err_count;

  dircc_node_msg_rx_writer #(
    .BASE_ADDR(BASE), .NUM_SLOTS(NSLOT), .SLOT_WORDS(SW), .ADDR_W(15)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
    .cpu_release(cpu_release), .irq_enable(irq_enable),
    .rd_slot(rd_slot), .wr_slot(wr_slot), .used(used), .irq(irq),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  n_chk = 0;
  int  n_err = 0;
  int  ws    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every DUT write must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      chk("wr_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("wr_addr", 32'(mem_address), 32'(mon_e.a));
        chk("wr_data", 32'(mem_writedata), 32'(mon_e.d));
        chk("wr_be", 32'({mem_chipselect, mem_byteenable}), 32'h7);
      end
    end
  end

  task automatic send_flit(input logic [15:0] d, input logic sop, input logic eop);
    bit ok, a;
    ok = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop;
    for (int t = 0; t < 200; t++) begin
      a = in_ready;
      @(posedge clk);
      if (a) begin ok = 1; break; end
      @(negedge clk);
    end
    #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    if (!ok) chk("accept_timeout", 32'(ok), 1);
  endtask

  task automatic send_pkt(input int len, input logic [15:0] d0);
    logic [14:0] b;
    logic [15:0] d;
    b = 15'(BASE + ws * SW);
    for (int i = 1; i <= len; i++) begin
      d = d0 + 16'(i - 1);
      if (i <= SW - 1) sb.push_back({b + 15'(i), d});
      send_flit(d, i == 1, i == len);
    end
    sb.push_back({b, (len > SW - 1) ? 1'b1 : 1'b0, 1'b0, 14'(len)});
    ws = (ws + 1) % NSLOT;
  endtask

  task automatic pulse_release();
    @(negedge clk); cpu_release = 1'b1;
    @(negedge clk); cpu_release = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; cpu_release = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_write", 32'({mem_write, mem_chipselect, mem_byteenable}), 0);
    chk("rst_addr", 32'(mem_address), 0);
    chk("rst_wdata", 32'(mem_writedata), 0);
    chk("rst_ptrs", 32'({rd_slot, wr_slot, used}), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_clken", 32'(mem_clken), 1);
    reset = 1'b0;
    ws = 0;
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
    cpu_release = 1'b0; irq_enable = 1'b1;

    // 3-flit packet, used/irq timing relative to the length write
    do_reset();
    chk("idle_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("idle_ready1", 32'(in_ready), 1);
    send_pkt(1, 16'h0000);
    drain();
    do_reset();
    sb.push_back({15'd16385, 16'hA001});
    sb.push_back({15'd16386, 16'hA002});
    sb.push_back({15'd16387, 16'hA003});
    send_flit(16'hA001, 1, 0);
    send_flit(16'hA002, 0, 0);
    send_flit(16'hA003, 0, 1);
    sb.push_back({15'd16384, 16'h0003});
    repeat (3) @(negedge clk);
    chk("t1_used_before", 32'(used), 0);
    chk("t1_irq_before", 32'(irq), 0);
    chk("t1_wr_slot", 32'(wr_slot), 1);
    @(negedge clk);
    chk("t1_used_after", 32'(used), 1);
    chk("t1_irq_after", 32'(irq), 1);
    drain();

    // 300-flit packet truncated to the slot
    do_reset();
    send_pkt(300, 16'h2000);
    drain();
    chk("t2_wr_slot", 32'(wr_slot), 1);
    chk("t2_used", 32'(used), 1);

    // Fill all slots, ninth packet stalls until a release
    do_reset();
    for (int i = 0; i < NSLOT; i++) send_pkt(1, 16'h3000 + 16'(i));
    drain();
    chk("t3_used_full", 32'(used), 8);
    chk("t3_ready_full", 32'(in_ready), 0);
    fork
      send_pkt(1, 16'h3999);
      begin
        repeat (4) @(negedge clk);
        chk("t3_stalled", 32'(in_ready), 0);
        pulse_release();
      end
    join
    drain();
    chk("t3_rd_slot", 32'(rd_slot), 1);
    chk("t3_used_end", 32'(used), 8);
    chk("t3_wr_slot", 32'(wr_slot), 1);

    // Release coinciding with the delayed used increment
    do_reset();
    for (int i = 0; i < 3; i++) send_pkt(1, 16'h4000 + 16'(i));
    drain();
    chk("t4_used3", 32'(used), 3);
    send_pkt(1, 16'h4100);
    repeat (3) @(negedge clk);
    cpu_release = 1'b1;
    @(negedge clk);
    cpu_release = 1'b0;
    chk("t4_used", 32'(used), 3);
    chk("t4_rd_slot", 32'(rd_slot), 1);
    chk("t4_wr_slot", 32'(wr_slot), 4);
    drain();
    chk("t4_used_settled", 32'(used), 3);

    // Protocol errors: stray flit in IDLE, release with nothing filled
    do_reset();
    send_flit(16'h5555, 0, 0);
    pulse_release();
    drain();
    chk("t5_err", 32'(err_count), 2);
    chk("t5_used", 32'(used), 0);
    chk("t5_rd_slot", 32'(rd_slot), 0);

    // Reset in the middle of a packet
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      sb.push_back({15'(BASE + i), 16'h6000 + 16'(i)});
      send_flit(16'h6000 + 16'(i), i == 1, 0);
    end
    do_reset();
    send_pkt(1, 16'h6100);
    drain();
    chk("t6_used", 32'(used), 1);
    chk("t6_wr_slot", 32'(wr_slot), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
